// File: rtl/vector_mem_serdes.sv
// vector_mem_serdes: moves a vector register to and from a narrow memory
// port one word (beat) at a time. A load reads BEATS words, assembles them
// into an N-bit vector and writes it to the vector register file. A store
// slices a latched vector into BEATS words and writes them out.
// Optional feature macro: VECTOR_STORE_PATH_EN (store path). When the macro
// is undefined the store path is absent and st_start completes with err.
module vector_mem_serdes #(
  parameter int N     = 256,
  parameter int W     = 32,
  parameter int BEATS = N / W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          st_start,
  input  logic [31:0]   base_addr,
  input  logic [4:0]    vdst,
  input  logic [N-1:0]  vsrc_data,
  output logic [31:0]   mem_addr,
  output logic          mem_rd_en,
  input  logic [W-1:0]  mem_rd_data,
  input  logic          mem_rd_valid,
  output logic          mem_wr_en,
  output logic [W-1:0]  mem_wr_data,
  input  logic          mem_wr_ready,
  output logic [N-1:0]  VWD3,
  output logic          VWE3,
  output logic [4:0]    VA3,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);

`ifdef VECTOR_STORE_PATH_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_REQ  = 3'd1,
    LD_WAIT = 3'd2,
    LD_WB   = 3'd3,
    ST_WR   = 3'd4,
    DONE    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_REQ  = 3'd1,
    LD_WAIT = 3'd2,
    LD_WB   = 3'd3,
    DONE    = 3'd5
  } state_t;
`endif

  state_t         state_r;
  state_t         state_s;
  logic [31:0]    base_r;
  logic [4:0]     vdst_r;
  logic [N-1:0]   vec_r;
  logic [KW-1:0]  beat_r;
  logic           err_r;
  logic [31:0]    beat_addr_s;

  // Byte address of the current beat: base plus four bytes per beat.
  assign beat_addr_s = base_r + {{(32-KW-2){1'b0}}, beat_r, 2'b00};

`ifndef VECTOR_STORE_PATH_EN
  // Store-side inputs have no consumer in this build.
  logic unused_store_s;
  assign unused_store_s = ^{vsrc_data, mem_wr_ready};
`endif

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start requests are only honoured in IDLE, load first.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ld_start) begin
          state_s = LD_REQ;
        end else if (st_start) begin
`ifdef VECTOR_STORE_PATH_EN
          state_s = ST_WR;
`else
          state_s = DONE;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      LD_REQ: state_s = LD_WAIT;
      LD_WAIT: begin
        if (mem_rd_valid) begin
          state_s = (beat_r == LAST_BEAT) ? LD_WB : LD_REQ;
        end else begin
          state_s = LD_WAIT;
        end
      end
      LD_WB: state_s = DONE;
`ifdef VECTOR_STORE_PATH_EN
      ST_WR: begin
        if (mem_wr_ready && (beat_r == LAST_BEAT)) begin
          state_s = DONE;
        end else begin
          state_s = ST_WR;
        end
      end
`endif
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: latch the request, step the beat counter, gather read lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r <= 32'd0;
      vdst_r <= 5'd0;
      vec_r  <= '0;
      beat_r <= '0;
      err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ld_start) begin
            base_r <= base_addr;
            vdst_r <= vdst;
            vec_r  <= '0;
            beat_r <= '0;
            err_r  <= ~vdst[4];
          end else if (st_start) begin
            base_r <= base_addr;
            beat_r <= '0;
`ifdef VECTOR_STORE_PATH_EN
            vec_r  <= vsrc_data;
            err_r  <= 1'b0;
`else
            err_r  <= 1'b1;
`endif
          end
        end
        LD_WAIT: begin
          if (mem_rd_valid) begin
            vec_r[beat_r*W +: W] <= mem_rd_data;
            if (beat_r != LAST_BEAT) begin
              beat_r <= beat_r + KW'(1);
            end
          end
        end
`ifdef VECTOR_STORE_PATH_EN
        ST_WR: begin
          if (mem_wr_ready && (beat_r != LAST_BEAT)) begin
            beat_r <= beat_r + KW'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from registered state; everything is zero in IDLE.
  always_comb begin
    mem_addr    = 32'd0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    VWD3        = '0;
    VWE3        = 1'b0;
    VA3         = 5'd0;
    done        = 1'b0;
    err         = 1'b0;
    busy        = (state_r != IDLE);
    case (state_r)
      LD_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = beat_addr_s;
      end
      LD_WB: begin
        VWD3 = vec_r;
        VA3  = vdst_r;
        VWE3 = vdst_r[4];
      end
`ifdef VECTOR_STORE_PATH_EN
      ST_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = beat_addr_s;
        mem_wr_data = vec_r[beat_r*W +: W];
      end
`endif
      DONE: begin
        done = 1'b1;
        err  = err_r;
      end
      default: begin
      end
    endcase
  end

endmodule
